// File: rtl/apb_alu_engine_if.sv
// APB3 bus bundle between a CPU-side master and the ALU engine slave.
// Latency: none; wires only.
// Backpressure: none; the slave always completes with zero wait states.
interface apb_alu_engine_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_alu_engine.sv
// APB3 slave ALU: operands A/B, a command word, NUM_RES result registers, sticky status.
// Latency: command accepted at access cycle T, result readable from T+3; APB has zero wait states.
// Backpressure: none on APB; a CMD issued while busy is rejected with pslverr and STATUS.err.
// Build option: define ALU_IRQ_EN to add a level interrupt output irq = done | err.
module apb_alu_engine #(
   parameter int DATA_W  = 8,
   parameter int NUM_RES = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   apb_alu_engine_if.slave    apb,
   output logic               busy
`ifdef ALU_IRQ_EN
   ,
   output logic               irq
`endif
);

   localparam int RW    = DATA_W + 1;
   localparam int IDX_W = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

   state_t            state;
   logic [DATA_W-1:0] opa_q, opb_q;
   logic [DATA_W-1:0] a_q, b_q;
   logic [3:0]        op_q;
   logic [4:0]        sh_q;
   logic [IDX_W-1:0]  dest_q;
   logic [RW-1:0]     r_q;
   logic [RW-1:0]     alu_r;
   logic [RW-1:0]     res_mem [2**IDX_W];
   logic              done_q, err_q;

   logic              access, wr_acc;
   logic [9:0]        word;
   logic [5:0]        ridx;
   logic              sel_cmd, sel_opa, sel_opb, sel_stat, res_hit;
   logic [3:0]        cmd_op;
   logic [4:0]        cmd_sh;
   logic [5:0]        cmd_dest;
   logic              op_ok, dest_ok, cmd_wr, cmd_rej, cmd_go, stat_wr;
   logic [31:0]       rd_data;
   logic              err_c;

   // address decode and command qualification
   assign access   = apb.psel & apb.penable;
   assign wr_acc   = access & apb.pwrite;
   assign word     = apb.paddr[11:2];
   assign ridx     = apb.paddr[7:2];
   assign sel_cmd  = (word == 10'h000);
   assign sel_opa  = (word == 10'h001);
   assign sel_opb  = (word == 10'h002);
   assign sel_stat = (word == 10'h003);
   assign res_hit  = (apb.paddr[11:8] == 4'h1) && ({1'b0, ridx} < 7'(NUM_RES));
   assign cmd_op   = apb.pwdata[3:0];
   assign cmd_sh   = apb.pwdata[8:4];
   assign cmd_dest = apb.pwdata[21:16];
   assign op_ok    = (cmd_op >= 4'h1) && (cmd_op <= 4'hA);
   assign dest_ok  = ({1'b0, cmd_dest} < 7'(NUM_RES));
   assign cmd_wr   = wr_acc & sel_cmd;
   assign cmd_rej  = cmd_wr & (busy | ~op_ok | ~dest_ok);
   assign cmd_go   = cmd_wr & ~cmd_rej;
   assign stat_wr  = wr_acc & sel_stat;

   // bits of the bus that carry no meaning for this block
   logic unused_bits;
   assign unused_bits = &{1'b0, apb.paddr[1:0], apb.pwdata[31:22], apb.pwdata[15:9]};

   // zero-wait APB response; data and error only meaningful during the access cycle
   always_comb begin
      rd_data = '0;
      err_c   = 1'b0;
      if (sel_cmd)       err_c = apb.pwrite ? cmd_rej : 1'b1;
      else if (sel_opa)  rd_data = 32'(opa_q);
      else if (sel_opb)  rd_data = 32'(opb_q);
      else if (sel_stat) rd_data = 32'({err_q, done_q, busy});
      else if (res_hit) begin
         if (apb.pwrite) err_c = 1'b1;
         else            rd_data = 32'(res_mem[ridx[IDX_W-1:0]]);
      end
      else               err_c = 1'b1;
   end

   assign apb.pready  = access;
   assign apb.pslverr = access & err_c;
   assign apb.prdata  = (access & ~apb.pwrite & ~err_c) ? rd_data : 32'h0;

   // ALU datapath on the operands latched at command acceptance
   always_comb begin
      alu_r = '0;
      case (op_q)
         4'h1: alu_r = {1'b0, a_q} + {1'b0, b_q};
         4'h2: alu_r = {1'b0, a_q} - {1'b0, b_q};
         4'h3: alu_r = {1'b0, a_q} << sh_q;
         4'h4: alu_r = {1'b0, a_q >> sh_q};
         4'h5: alu_r = {1'b0, a_q & b_q};
         4'h6: alu_r = {1'b0, a_q | b_q};
         4'h7: alu_r = {1'b0, ~(a_q & b_q)};
         4'h8: alu_r = {1'b0, ~(a_q | b_q)};
         4'h9: alu_r = {1'b0, a_q ^ b_q};
         4'hA: begin
            if (a_q > b_q)      alu_r = RW'(1);
            else if (a_q < b_q) alu_r = RW'(2);
            else                alu_r = {1'b1, {DATA_W{1'b0}}};
         end
         default: alu_r = '0;
      endcase
   end

   // IDLE -> EXEC -> WB sequencer; owns the latched command and the result file
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         busy   <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         sh_q   <= '0;
         dest_q <= '0;
         r_q    <= '0;
         for (int i = 0; i < 2**IDX_W; i++) res_mem[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_go) begin
                  a_q    <= opa_q;
                  b_q    <= opb_q;
                  op_q   <= cmd_op;
                  sh_q   <= cmd_sh;
                  dest_q <= cmd_dest[IDX_W-1:0];
                  busy   <= 1'b1;
                  state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_q   <= alu_r;
               state <= S_WB;
            end
            S_WB: begin
               res_mem[dest_q] <= r_q;
               busy            <= 1'b0;
               state           <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // software-visible operand and sticky status registers; hardware set beats W1C
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         opa_q  <= '0;
         opb_q  <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (wr_acc && sel_opa) opa_q <= apb.pwdata[DATA_W-1:0];
         if (wr_acc && sel_opb) opb_q <= apb.pwdata[DATA_W-1:0];
         done_q <= (state == S_WB) | (done_q & ~(stat_wr & apb.pwdata[1]));
         err_q  <= cmd_rej         | (err_q  & ~(stat_wr & apb.pwdata[2]));
      end
   end

`ifdef ALU_IRQ_EN
   assign irq = done_q | err_q;
`endif

endmodule
